// File: rtl/rx_frame_7o1.sv
// rx_frame_7o1: 7O1 serial receiver and game-state frame parser.
// Characters are 7 data bits sent LSB first, then an odd parity bit and one stop bit.
// Frame layout: STX, HEAD, APPLE, STATE, MODES, LF.
// A good frame updates all field outputs together and raises frame_valid for one cycle.
//
// Character FSM
//   state    | meaning
//   C_IDLE   | line idle, waiting for a synced falling edge
//   C_START  | timing to mid start bit, rejects glitches
//   C_DATA   | sampling 7 data bits at mid-bit
//   C_PARITY | sampling the parity bit
//   C_STOP   | sampling the stop bit, emits char_done
//   C_BREAK  | stop bit was low, waiting for the line to return high
//
// Frame FSM (db_estado code)
//   state          | meaning
//   F_WAIT_STX (0) | hunting for STX
//   F_HEAD     (1) | expecting HEAD
//   F_APPLE    (2) | expecting APPLE
//   F_STATE    (3) | expecting STATE
//   F_MODES    (4) | expecting MODES
//   F_WAIT_LF  (5) | expecting LF, which commits the shadows
module rx_frame_7o1 #(
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [5:0] head,
  output logic [5:0] apple,
  output logic [5:0] state,
  output logic       comeu_maca,
  output logic       difficulty_out,
  output logic       mode_out,
  output logic       velocity_out,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       parity_error,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [TW-1:0] ONE       = TW'(1);
  localparam logic [6:0]    CHAR_STX  = 7'h02;
  localparam logic [6:0]    CHAR_LF   = 7'h0A;

  typedef enum logic [2:0] {
    C_IDLE   = 3'd0,
    C_START  = 3'd1,
    C_DATA   = 3'd2,
    C_PARITY = 3'd3,
    C_STOP   = 3'd4,
    C_BREAK  = 3'd5
  } char_state_t;

  typedef enum logic [2:0] {
    F_WAIT_STX = 3'd0,
    F_HEAD     = 3'd1,
    F_APPLE    = 3'd2,
    F_STATE    = 3'd3,
    F_MODES    = 3'd4,
    F_WAIT_LF  = 3'd5
  } frame_state_t;

  logic          sync_q1, sync_q2, sync_q3;
  logic          rx_bit, rx_fall;
  char_state_t   c_state, c_nxt;
  logic [TW-1:0] timer;
  logic          tick;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift_q;
  logic          par_q;
  logic          char_done, char_bad, parity_ok;
  logic [6:0]    char_data;

  frame_state_t  f_state, f_nxt;
  logic          valid_nxt, err_nxt;
  logic          ld_head, ld_apple, ld_state, ld_modes;
  logic [5:0]    sh_head, sh_apple, sh_state;
  logic [3:0]    sh_modes;

  assign rx_bit    = sync_q2;
  assign rx_fall   = sync_q3 & ~sync_q2;
  assign tick      = (timer == '0);
  assign char_data = shift_q;
  assign parity_ok = ^{shift_q, par_q};
  assign db_estado = {1'b0, f_state};

  // Bring the asynchronous line into the clock domain and keep one extra stage for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      sync_q3 <= 1'b1;
    end else begin
      sync_q1 <= entrada_serial;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  // Character FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) c_state <= C_IDLE;
    else        c_state <= c_nxt;
  end

  // Character FSM next state; char_done fires in the stop-sample cycle itself.
  always_comb begin
    c_nxt     = c_state;
    char_done = 1'b0;
    char_bad  = 1'b0;
    case (c_state)
      C_IDLE:   if (rx_fall) c_nxt = C_START;
      C_START:  if (tick) c_nxt = rx_bit ? C_IDLE : C_DATA;
      C_DATA:   if (tick && bit_cnt == 3'd6) c_nxt = C_PARITY;
      C_PARITY: if (tick) c_nxt = C_STOP;
      C_STOP: begin
        if (tick) begin
          char_done = 1'b1;
          if (rx_bit) begin
            c_nxt = C_IDLE;
          end else begin
            char_bad = 1'b1;
            c_nxt    = C_BREAK;
          end
        end
      end
      C_BREAK:  if (rx_bit) c_nxt = C_IDLE;
      default:  c_nxt = C_IDLE;
    endcase
  end

  // Bit timer (down-counter, acts on zero), bit counter and data/parity capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer   <= HALF_LOAD;
      bit_cnt <= 3'd0;
      shift_q <= 7'd0;
      par_q   <= 1'b0;
    end else begin
      case (c_state)
        C_IDLE, C_BREAK: begin
          timer   <= HALF_LOAD;
          bit_cnt <= 3'd0;
        end
        C_START: timer <= tick ? FULL_LOAD : timer - ONE;
        C_DATA: begin
          if (tick) begin
            shift_q <= {rx_bit, shift_q[6:1]};
            bit_cnt <= bit_cnt + 3'd1;
            timer   <= FULL_LOAD;
          end else begin
            timer <= timer - ONE;
          end
        end
        C_PARITY: begin
          if (tick) begin
            par_q <= rx_bit;
            timer <= FULL_LOAD;
          end else begin
            timer <= timer - ONE;
          end
        end
        C_STOP:  if (!tick) timer <= timer - ONE;
        default: timer <= HALF_LOAD;
      endcase
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) f_state <= F_WAIT_STX;
    else        f_state <= f_nxt;
  end

  // Frame FSM next state, shadow load enables and pulse requests.
  always_comb begin
    f_nxt     = f_state;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    ld_head   = 1'b0;
    ld_apple  = 1'b0;
    ld_state  = 1'b0;
    ld_modes  = 1'b0;
    if (char_done) begin
      if (char_bad || !parity_ok) begin
        // Corrupt characters are only worth reporting once a frame is open.
        if (f_state != F_WAIT_STX) begin
          err_nxt = 1'b1;
          f_nxt   = F_WAIT_STX;
        end
      end else if (char_data == CHAR_STX) begin
        err_nxt = (f_state != F_WAIT_STX);
        f_nxt   = F_HEAD;
      end else begin
        case (f_state)
          F_HEAD, F_APPLE, F_STATE: begin
            if (char_data[0]) begin
              ld_head  = (f_state == F_HEAD);
              ld_apple = (f_state == F_APPLE);
              ld_state = (f_state == F_STATE);
              f_nxt    = frame_state_t'(f_state + 3'd1);
            end else begin
              err_nxt = 1'b1;
              f_nxt   = F_WAIT_STX;
            end
          end
          F_MODES: begin
            if (char_data[2:0] == 3'b001) begin
              ld_modes = 1'b1;
              f_nxt    = F_WAIT_LF;
            end else begin
              err_nxt = 1'b1;
              f_nxt   = F_WAIT_STX;
            end
          end
          F_WAIT_LF: begin
            valid_nxt = (char_data == CHAR_LF);
            err_nxt   = (char_data != CHAR_LF);
            f_nxt     = F_WAIT_STX;
          end
          default: f_nxt = F_WAIT_STX;
        endcase
      end
    end
  end

  // Shadow fields collect a frame in progress so the outputs only ever change as a whole.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_head  <= 6'd0;
      sh_apple <= 6'd0;
      sh_state <= 6'd0;
      sh_modes <= 4'd0;
    end else begin
      if (ld_head)  sh_head  <= char_data[6:1];
      if (ld_apple) sh_apple <= char_data[6:1];
      if (ld_state) sh_state <= char_data[6:1];
      if (ld_modes) sh_modes <= char_data[6:3];
    end
  end

  // Published fields and status pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head           <= 6'd0;
      apple          <= 6'd0;
      state          <= 6'd0;
      comeu_maca     <= 1'b0;
      difficulty_out <= 1'b0;
      mode_out       <= 1'b0;
      velocity_out   <= 1'b0;
      frame_valid    <= 1'b0;
      frame_error    <= 1'b0;
      parity_error   <= 1'b0;
    end else begin
      frame_valid  <= valid_nxt;
      frame_error  <= err_nxt;
      parity_error <= char_done & ~parity_ok;
      if (valid_nxt) begin
        head           <= sh_head;
        apple          <= sh_apple;
        state          <= sh_state;
        comeu_maca     <= sh_modes[3];
        difficulty_out <= sh_modes[2];
        mode_out       <= sh_modes[1];
        velocity_out   <= sh_modes[0];
      end
    end
  end

endmodule
